// File: rtl/alu_pkg.sv
// Shared ALU function codes and multiplier-sequencer state encoding.
// fn bit order follows the Hack ALU: {zx, nx, zy, ny, f, no}.
package alu_pkg;

  localparam int          W         = 16;
  localparam logic [5:0]  FN_ADD    = 6'b000010;
  localparam logic [5:0]  FN_PASS_X = 6'b001100;
  localparam logic [4:0]  LAST_BIT  = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/alu.sv
// Hack ALU: optional zero/negate of each operand, add or AND, optional output negate.
// fn = {zx, nx, zy, ny, f, no}.
module alu
  import alu_pkg::*;
(
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [5:0]   fn_i,
  output logic [W-1:0] out_o,
  output logic         zr_o,
  output logic         ng_o
);

  logic [W-1:0] x_z, x_n, y_z, y_n, res;

  always_comb begin
    x_z   = fn_i[5] ? '0 : x_i;
    x_n   = fn_i[4] ? ~x_z : x_z;
    y_z   = fn_i[3] ? '0 : y_i;
    y_n   = fn_i[2] ? ~y_z : y_z;
    res   = fn_i[1] ? (x_n + y_n) : (x_n & y_n);
    out_o = fn_i[0] ? ~res : res;
  end

  assign zr_o = ~|out_o;
  assign ng_o = out_o[W-1];

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 multiplier (low 16 bits) that issues every add and doubling
// through a single Hack ALU instance. ADD/DBL alternate 16 times unless EARLY_EXIT.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic         zr,
  output logic         ng
);

  mul_state_e   state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] mcand_q, mcand_d;
  logic [W-1:0] mplier_q, mplier_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [W-1:0] prod_q, prod_d;

  logic [W-1:0] alu_x, alu_y, alu_out;
  logic [5:0]   alu_fn;
  logic         alu_zr, alu_ng;
  logic [1:0]   unused_alu_flags;

  // Operand mux: ADD accumulates, DBL doubles the multiplicand, otherwise pass acc.
  always_comb begin
    alu_x  = acc_q;
    alu_y  = '0;
    alu_fn = FN_PASS_X;
    unique case (state_q)
      ADD: begin
        alu_x  = acc_q;
        alu_y  = mcand_q;
        alu_fn = FN_ADD;
      end
      DBL: begin
        alu_x  = mcand_q;
        alu_y  = mcand_q;
        alu_fn = FN_ADD;
      end
      default: ;
    endcase
  end

  alu u_alu (
    .x_i   (alu_x),
    .y_i   (alu_y),
    .fn_i  (alu_fn),
    .out_o (alu_out),
    .zr_o  (alu_zr),
    .ng_o  (alu_ng)
  );

  // Result flags come from the product register, not from the ALU.
  assign unused_alu_flags = {alu_zr, alu_ng};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          cnt_d    = '0;
          state_d  = ADD;
        end
      end
      ADD: begin
        if (EARLY_EXIT && (mplier_q == '0)) begin
          prod_d  = acc_q;
          state_d = DONE;
        end else begin
          if (mplier_q[0]) acc_d = alu_out;
          state_d = DBL;
        end
      end
      DBL: begin
        mcand_d  = alu_out;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == LAST_BIT) begin
          prod_d  = acc_q;
          state_d = DONE;
        end else begin
          state_d = ADD;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = prod_q;
  assign zr        = ~|prod_q;
  assign ng        = prod_q[W-1];

endmodule
